// File: rtl/fwd_hazard_sb_u.sv
// EX-stage forwarding unit with a multicycle completion-bus bypass and an
// ID-stage hazard detector backed by a busy-register scoreboard.
module fwd_hazard_sb_u #(
    parameter int AW      = 5,
    parameter int NSRC    = 2,
    parameter int MAX_OUT = 4,
    parameter int CNT_W   = 16,
    localparam int OW     = $clog2(MAX_OUT + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NSRC*AW-1:0]   ifid_rs,
    input  logic [NSRC-1:0]      ifid_rs_use,
    input  logic [AW-1:0]        ifid_rd,
    input  logic                 ifid_reg_write,
    input  logic                 ifid_mc,
    input  logic [NSRC*AW-1:0]   idex_rs,
    input  logic [AW-1:0]        idex_rd,
    input  logic                 idex_mem_read,
    input  logic                 exmem_reg_write,
    input  logic [AW-1:0]        exmem_rd,
    input  logic                 memwb_reg_write,
    input  logic [AW-1:0]        memwb_rd,
    input  logic                 mc_done,
    input  logic [AW-1:0]        mc_done_rd,
    output logic [2*NSRC-1:0]    forward_sel,
    output logic                 stall,
    output logic                 mc_issue,
    output logic [OW-1:0]        outstanding,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic                 err_spurious
);

    localparam int NREG = 1 << AW;

    logic [NREG-1:0]  busy_reg, busy_next;
    logic [OW-1:0]    outstanding_reg, outstanding_next;
    logic [CNT_W-1:0] stall_cnt_reg;
    logic             err_spurious_reg;

    logic [NSRC-1:0]  load_use_op, raw_mc_op;
    logic             waw_mc, full, stall_raw, valid_done;

    generate
        for (genvar gi = 0; gi < NSRC; gi++) begin : g_op
            logic [AW-1:0] ex_src, id_src;
            logic [1:0]    sel;
            logic          chk;

            assign ex_src = idex_rs[gi*AW +: AW];
            assign id_src = ifid_rs[gi*AW +: AW];

            always_comb begin
                sel = 2'd0;
                if (ex_src != '0) begin
                    if (exmem_reg_write && exmem_rd == ex_src)
                        sel = 2'd2;
                    else if (memwb_reg_write && memwb_rd == ex_src)
                        sel = 2'd1;
                    else if (mc_done && mc_done_rd == ex_src)
                        sel = 2'd3;
                end
            end

            assign forward_sel[2*gi +: 2] = rst ? sel : 2'd0;

            assign chk            = ifid_rs_use[gi] && (id_src != '0);
            assign load_use_op[gi] = chk && idex_mem_read && (idex_rd == id_src);
            // Completion is only visible after busy clears, so no same-cycle bypass here.
            assign raw_mc_op[gi]   = chk && busy_reg[id_src];
        end
    endgenerate

    assign waw_mc    = ifid_reg_write && (ifid_rd != '0) && busy_reg[ifid_rd];
    assign full      = ifid_mc && (outstanding_reg == OW'(MAX_OUT));
    assign stall_raw = (|load_use_op) | (|raw_mc_op) | waw_mc | full;

    assign stall    = rst & stall_raw;
    assign mc_issue = rst & ifid_mc & ifid_reg_write & (ifid_rd != '0) & ~stall_raw;

    assign valid_done = mc_done && (mc_done_rd != '0) && busy_reg[mc_done_rd];

    always_comb begin
        busy_next = busy_reg;
        if (valid_done)
            busy_next[mc_done_rd] = 1'b0;
        if (mc_issue)
            busy_next[ifid_rd] = 1'b1;
    end

    always_comb begin
        outstanding_next = outstanding_reg;
        if (mc_issue && !valid_done)
            outstanding_next = outstanding_reg + OW'(1);
        else if (!mc_issue && valid_done && outstanding_reg != '0)
            outstanding_next = outstanding_reg - OW'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_reg         <= '0;
            outstanding_reg  <= '0;
            stall_cnt_reg    <= '0;
            err_spurious_reg <= 1'b0;
        end else begin
            busy_reg        <= busy_next;
            outstanding_reg <= outstanding_next;
            if (stall && stall_cnt_reg != {CNT_W{1'b1}})
                stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
            if (mc_done && !valid_done)
                err_spurious_reg <= 1'b1;
        end
    end

    assign outstanding  = outstanding_reg;
    assign stall_cnt    = stall_cnt_reg;
    assign err_spurious = err_spurious_reg;

endmodule

// File: tb/tb_fwd_hazard_sb_u.sv
// Scoreboard-driven bench for fwd_hazard_sb_u: expectations are queued when
// stimulus is applied and popped when the corresponding output is sampled.
module tb_fwd_hazard_sb_u;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [9:0] ifid_rs, idex_rs;
    logic [1:0] ifid_rs_use;
    logic [4:0] ifid_rd, idex_rd, exmem_rd, memwb_rd, mc_done_rd;
    logic       ifid_reg_write, ifid_mc, idex_mem_read;
    logic       exmem_reg_write, memwb_reg_write, mc_done;
    logic [3:0] forward_sel;
    logic       stall, mc_issue, err_spurious;
    logic [2:0] outstanding;
    logic [3:0] stall_cnt;

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;
    int   exp_cnt = 0;

    fwd_hazard_sb_u #(.AW(5), .NSRC(2), .MAX_OUT(4), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .ifid_rs(ifid_rs), .ifid_rs_use(ifid_rs_use), .ifid_rd(ifid_rd),
        .ifid_reg_write(ifid_reg_write), .ifid_mc(ifid_mc),
        .idex_rs(idex_rs), .idex_rd(idex_rd), .idex_mem_read(idex_mem_read),
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd),
        .mc_done(mc_done), .mc_done_rd(mc_done_rd),
        .forward_sel(forward_sel), .stall(stall), .mc_issue(mc_issue),
        .outstanding(outstanding), .stall_cnt(stall_cnt), .err_spurious(err_spurious)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "timeout");
    end

    function automatic int sat15(input int v);
        return (v > 15) ? 15 : v;
    endfunction

    task automatic idle();
        ifid_rs = '0; ifid_rs_use = '0; ifid_rd = '0; ifid_reg_write = 0; ifid_mc = 0;
        idex_rs = '0; idex_rd = '0; idex_mem_read = 0;
        exmem_reg_write = 0; exmem_rd = '0; memwb_reg_write = 0; memwb_rd = '0;
        mc_done = 0; mc_done_rd = '0;
    endtask

    task automatic push(input string name, input int val);
        exp_q.push_back('{name, 32'(val)});
    endtask

    task automatic test_reset();
        idle();
        ifid_rs = 10'($urandom); ifid_rs_use = 2'($urandom); ifid_rd = 5'($urandom);
        ifid_reg_write = 1'($urandom); ifid_mc = 1'($urandom);
        idex_rd = 5'($urandom); idex_mem_read = 1'($urandom);
        memwb_reg_write = 1'($urandom); memwb_rd = 5'($urandom);
        mc_done = 1'($urandom); mc_done_rd = 5'($urandom);
        exmem_reg_write = 1; exmem_rd = 5'd3; idex_rs = {5'($urandom), 5'd3};
        push("rst_fwd", 0); push("rst_stall", 0); push("rst_issue", 0);
        push("rst_out", 0); push("rst_cnt", 0); push("rst_err", 0);
        repeat (2) @(posedge clk);
        #1;
        e = exp_q.pop_front(); checks++; if (32'(forward_sel) !== e.val) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, forward_sel, e.val); end else $display("check %s = %0d", e.name, forward_sel);
        e = exp_q.pop_front(); checks++; if (32'(stall) !== e.val) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, stall, e.val); end else $display("check %s = %0d", e.name, stall);
        e = exp_q.pop_front(); checks++; if (32'(mc_issue) !== e.val) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, mc_issue, e.val); end else $display("check %s = %0d", e.name, mc_issue);
        e = exp_q.pop_front(); checks++; if (32'(outstanding) !== e.val) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, outstanding, e.val); end else $display("check %s = %0d", e.name, outstanding);
        e = exp_q.pop_front(); checks++; if (32'(stall_cnt) !== e.val) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, stall_cnt, e.val); end else $display("check %s = %0d", e.name, stall_cnt);
        e = exp_q.pop_front(); checks++; if (32'(err_spurious) !== e.val) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, err_spurious, e.val); end else $display("check %s = %0d", e.name, err_spurious);
        @(negedge clk);
        rst = 1;
        push("rel_fwd0", 2);
        #1;
        e = exp_q.pop_front(); checks++; if (32'(forward_sel[1:0]) !== e.val) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, forward_sel[1:0], e.val); end else $display("check %s = %0d", e.name, forward_sel[1:0]);
        idle();
        exp_cnt = 0;
    endtask

    task automatic test_forward();
        @(negedge clk);
        exmem_reg_write = 1; exmem_rd = 5'd5; memwb_reg_write = 1; memwb_rd = 5'd5;
        idex_rs = {5'd0, 5'd5};
        push("fwd_exmem", 2);
        #1;
        e = exp_q.pop_front(); checks++; if (32'(forward_sel[1:0]) !== e.val) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, forward_sel[1:0], e.val); end else $display("check %s = %0d", e.name, forward_sel[1:0]);
        exmem_reg_write = 0;
        push("fwd_memwb", 1);
        #1;
        e = exp_q.pop_front(); checks++; if (32'(forward_sel[1:0]) !== e.val) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, forward_sel[1:0], e.val); end else $display("check %s = %0d", e.name, forward_sel[1:0]);
        memwb_reg_write = 0; mc_done = 1; mc_done_rd = 5'd5; idex_rs = {5'd5, 5'd5};
        push("fwd_mc0", 3); push("fwd_mc1", 3);
        #1;
        e = exp_q.pop_front(); checks++; if (32'(forward_sel[1:0]) !== e.val) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, forward_sel[1:0], e.val); end else $display("check %s = %0d", e.name, forward_sel[1:0]);
        e = exp_q.pop_front(); checks++; if (32'(forward_sel[3:2]) !== e.val) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, forward_sel[3:2], e.val); end else $display("check %s = %0d", e.name, forward_sel[3:2]);
        idex_rs = {5'd5, 5'd0}; exmem_reg_write = 1; exmem_rd = 5'd0;
        push("fwd_r0", 0);
        #1;
        e = exp_q.pop_front(); checks++; if (32'(forward_sel[1:0]) !== e.val) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, forward_sel[1:0], e.val); end else $display("check %s = %0d", e.name, forward_sel[1:0]);
        idle();
    endtask

    task automatic test_load_use();
        @(negedge clk);
        idex_mem_read = 1; idex_rd = 5'd7; ifid_rs = {5'd7, 5'd0}; ifid_rs_use = 2'b10;
        push("lu_stall", 1);
        #1;
        e = exp_q.pop_front(); checks++; if (32'(stall) !== e.val) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, stall, e.val); end else $display("check %s = %0d", e.name, stall);
        @(negedge clk);
        idle();
        exp_cnt = sat15(exp_cnt + 1);
        push("lu_release", 0); push("lu_cnt", exp_cnt);
        #1;
        e = exp_q.pop_front(); checks++; if (32'(stall) !== e.val) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, stall, e.val); end else $display("check %s = %0d", e.name, stall);
        e = exp_q.pop_front(); checks++; if (32'(stall_cnt) !== e.val) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, stall_cnt, e.val); end else $display("check %s = %0d", e.name, stall_cnt);
        idex_mem_read = 1; idex_rd = 5'd7; ifid_rs = {5'd7, 5'd0}; ifid_rs_use = 2'b00;
        push("lu_unused", 0);
        #1;
        e = exp_q.pop_front(); checks++; if (32'(stall) !== e.val) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, stall, e.val); end else $display("check %s = %0d", e.name, stall);
        @(negedge clk);
        idle();
        push("lu_cnt_hold", exp_cnt);
        #1;
        e = exp_q.pop_front(); checks++; if (32'(stall_cnt) !== e.val) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, stall_cnt, e.val); end else $display("check %s = %0d", e.name, stall_cnt);
    endtask

    task automatic test_raw_mc();
        @(negedge clk);
        ifid_mc = 1; ifid_reg_write = 1; ifid_rd = 5'd9;
        push("raw_issue", 1);
        #1;
        e = exp_q.pop_front(); checks++; if (32'(mc_issue) !== e.val) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, mc_issue, e.val); end else $display("check %s = %0d", e.name, mc_issue);
        @(negedge clk);
        idle();
        ifid_rs = {5'd0, 5'd9}; ifid_rs_use = 2'b01;
        push("raw_out1", 1); push("raw_stall", 1);
        #1;
        e = exp_q.pop_front(); checks++; if (32'(outstanding) !== e.val) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, outstanding, e.val); end else $display("check %s = %0d", e.name, outstanding);
        e = exp_q.pop_front(); checks++; if (32'(stall) !== e.val) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, stall, e.val); end else $display("check %s = %0d", e.name, stall);
        repeat (3) @(negedge clk);
        mc_done = 1; mc_done_rd = 5'd9;
        push("raw_done_stall", 1);
        #1;
        e = exp_q.pop_front(); checks++; if (32'(stall) !== e.val) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, stall, e.val); end else $display("check %s = %0d", e.name, stall);
        @(negedge clk);
        mc_done = 0; mc_done_rd = '0;
        exp_cnt = sat15(exp_cnt + 4);
        push("raw_free", 0); push("raw_out0", 0); push("raw_cnt", exp_cnt);
        #1;
        e = exp_q.pop_front(); checks++; if (32'(stall) !== e.val) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, stall, e.val); end else $display("check %s = %0d", e.name, stall);
        e = exp_q.pop_front(); checks++; if (32'(outstanding) !== e.val) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, outstanding, e.val); end else $display("check %s = %0d", e.name, outstanding);
        e = exp_q.pop_front(); checks++; if (32'(stall_cnt) !== e.val) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, stall_cnt, e.val); end else $display("check %s = %0d", e.name, stall_cnt);
        idle();
    endtask

    task automatic test_full();
        for (int r = 1; r <= 4; r++) begin
            @(negedge clk);
            ifid_mc = 1; ifid_reg_write = 1; ifid_rd = 5'(r);
            push($sformatf("full_issue_r%0d", r), 1);
            #1;
            e = exp_q.pop_front(); checks++; if (32'(mc_issue) !== e.val) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, mc_issue, e.val); end else $display("check %s = %0d", e.name, mc_issue);
        end
        @(negedge clk);
        ifid_rd = 5'd5;
        push("full_stall", 1); push("full_noissue", 0); push("full_out4", 4);
        #1;
        e = exp_q.pop_front(); checks++; if (32'(stall) !== e.val) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, stall, e.val); end else $display("check %s = %0d", e.name, stall);
        e = exp_q.pop_front(); checks++; if (32'(mc_issue) !== e.val) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, mc_issue, e.val); end else $display("check %s = %0d", e.name, mc_issue);
        e = exp_q.pop_front(); checks++; if (32'(outstanding) !== e.val) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, outstanding, e.val); end else $display("check %s = %0d", e.name, outstanding);
        @(negedge clk);
        mc_done = 1; mc_done_rd = 5'd2;
        push("full_done_stall", 1);
        #1;
        e = exp_q.pop_front(); checks++; if (32'(stall) !== e.val) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, stall, e.val); end else $display("check %s = %0d", e.name, stall);
        @(negedge clk);
        mc_done = 0; mc_done_rd = '0;
        exp_cnt = sat15(exp_cnt + 2);
        push("full_issue5", 1); push("full_out3", 3);
        #1;
        e = exp_q.pop_front(); checks++; if (32'(mc_issue) !== e.val) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, mc_issue, e.val); end else $display("check %s = %0d", e.name, outstanding == 3 ? mc_issue : mc_issue);
        e = exp_q.pop_front(); checks++; if (32'(outstanding) !== e.val) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, outstanding, e.val); end else $display("check %s = %0d", e.name, outstanding);
        @(negedge clk);
        idle();
        push("full_out_back4", 4); push("full_cnt", exp_cnt);
        #1;
        e = exp_q.pop_front(); checks++; if (32'(outstanding) !== e.val) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, outstanding, e.val); end else $display("check %s = %0d", e.name, outstanding);
        e = exp_q.pop_front(); checks++; if (32'(stall_cnt) !== e.val) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, stall_cnt, e.val); end else $display("check %s = %0d", e.name, stall_cnt);
        foreach (exp_q[i]) $display("leftover %s", exp_q[i].name);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            mc_done = 1; mc_done_rd = (k == 0) ? 5'd1 : 5'(k + 2);
        end
        @(negedge clk);
        idle();
        push("drain_out0", 0); push("drain_err0", 0);
        #1;
        e = exp_q.pop_front(); checks++; if (32'(outstanding) !== e.val) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, outstanding, e.val); end else $display("check %s = %0d", e.name, outstanding);
        e = exp_q.pop_front(); checks++; if (32'(err_spurious) !== e.val) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, err_spurious, e.val); end else $display("check %s = %0d", e.name, err_spurious);
    endtask

    task automatic test_spurious();
        @(negedge clk);
        mc_done = 1; mc_done_rd = 5'd12;
        @(negedge clk);
        idle();
        push("spur_err", 1); push("spur_out", 0);
        #1;
        e = exp_q.pop_front(); checks++; if (32'(err_spurious) !== e.val) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, err_spurious, e.val); end else $display("check %s = %0d", e.name, err_spurious);
        e = exp_q.pop_front(); checks++; if (32'(outstanding) !== e.val) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, outstanding, e.val); end else $display("check %s = %0d", e.name, outstanding);
        repeat (3) @(negedge clk);
        push("spur_sticky", 1);
        #1;
        e = exp_q.pop_front(); checks++; if (32'(err_spurious) !== e.val) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, err_spurious, e.val); end else $display("check %s = %0d", e.name, err_spurious);
    endtask

    task automatic test_midop_reset();
        @(negedge clk);
        ifid_mc = 1; ifid_reg_write = 1; ifid_rd = 5'd10;
        @(negedge clk);
        idle();
        push("mid_out1", 1);
        #1;
        e = exp_q.pop_front(); checks++; if (32'(outstanding) !== e.val) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, outstanding, e.val); end else $display("check %s = %0d", e.name, outstanding);
        rst = 0;
        exp_cnt = 0;
        push("mid_rst_out", 0); push("mid_rst_err", 0); push("mid_rst_cnt", 0);
        #1;
        e = exp_q.pop_front(); checks++; if (32'(outstanding) !== e.val) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, outstanding, e.val); end else $display("check %s = %0d", e.name, outstanding);
        e = exp_q.pop_front(); checks++; if (32'(err_spurious) !== e.val) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, err_spurious, e.val); end else $display("check %s = %0d", e.name, err_spurious);
        e = exp_q.pop_front(); checks++; if (32'(stall_cnt) !== e.val) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, stall_cnt, e.val); end else $display("check %s = %0d", e.name, stall_cnt);
        @(negedge clk);
        rst = 1;
        mc_done = 1; mc_done_rd = 5'd10;
        @(negedge clk);
        idle();
        push("mid_late_err", 1); push("mid_late_out", 0);
        #1;
        e = exp_q.pop_front(); checks++; if (32'(err_spurious) !== e.val) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, err_spurious, e.val); end else $display("check %s = %0d", e.name, err_spurious);
        e = exp_q.pop_front(); checks++; if (32'(outstanding) !== e.val) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, outstanding, e.val); end else $display("check %s = %0d", e.name, outstanding);
    endtask

    task automatic test_saturation();
        @(negedge clk);
        idex_mem_read = 1; idex_rd = 5'd7; ifid_rs = {5'd0, 5'd7}; ifid_rs_use = 2'b01;
        repeat (8) @(negedge clk);
        exp_cnt = sat15(exp_cnt + 8);
        push("sat_mid", exp_cnt);
        #1;
        e = exp_q.pop_front(); checks++; if (32'(stall_cnt) !== e.val) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, stall_cnt, e.val); end else $display("check %s = %0d", e.name, stall_cnt);
        repeat (11) @(negedge clk);
        idle();
        exp_cnt = sat15(exp_cnt + 11);
        push("sat_cnt", exp_cnt);
        #1;
        e = exp_q.pop_front(); checks++; if (32'(stall_cnt) !== e.val) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, stall_cnt, e.val); end else $display("check %s = %0d", e.name, stall_cnt);
    endtask

    initial begin
        test_reset();
        test_forward();
        test_load_use();
        test_raw_mc();
        test_full();
        test_spurious();
        test_midop_reset();
        test_saturation();
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
